psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Output accumulation stage for one column of the systolic MAC array.
- Takes the signed partial sum from the last row of the column, registers it, sign-extends it and accumulates it into a wide signed register.
- Clear and valid qualifiers travel alongside the data.
- Built from three leaf functions: an enable-able register stage, a signed width-extending adder, and a clearable accumulator register.

Parameters:
IN_WIDTH, 17, width of the signed partial-sum input (2*PMAX + clog2(ARRAY_N)); must be >= 2
OUT_WIDTH, 32, width of the signed accumulator output; must be >= IN_WIDTH

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
in_valid  input  1  qualifies in and clear in the current cycle
clear  input  1  restart accumulation with the current input
in  input  IN_WIDTH  signed two's-complement partial sum
out  output  OUT_WIDTH  signed accumulated value
out_valid  output  1  out reflects an update that consumed a valid input

Behaviour:
- Reset: reset=0 at a rising edge forces every register to 0 on that edge.
  - Registers: stage-1 data, stage-1 valid, stage-1 clear, accumulator, out_valid.
  - Hence out=0 and out_valid=0 from the following cycle.
  - Reset has priority over all other inputs.
- Stage 1 (input register, always enabled):
  - s1_in <= in; s1_valid <= in_valid; s1_clear <= clear.
- Adder:
  - Combinational signed add of sext(s1_in) to OUT_WIDTH and acc (OUT_WIDTH).
  - Result truncated to OUT_WIDTH, i.e. two's-complement wrap-around; no saturation, no overflow flag.
- Stage 2 (accumulator register), priority order:
  - s1_valid=1, s1_clear=1: acc <= sext(s1_in).
  - s1_valid=1, s1_clear=0: acc <= acc + sext(s1_in).
  - s1_valid=0, s1_clear=1: acc <= 0.
  - s1_valid=0, s1_clear=0: acc holds.
- Outputs:
  - out = acc (registered, no combinational path from inputs).
  - out_valid <= s1_valid, registered in parallel with acc.
  - out_valid is therefore high exactly in the cycle whose out contains the result of that valid input.
- Latency: input sampled at edge k appears on out/out_valid after edge k+1 (2-cycle latency). Throughput is one input per cycle, with no stalls and no backpressure.
- Consecutive clears each restart accumulation; gaps in in_valid do not disturb the accumulated value.
- Reset mid-stream flushes stage 1 as well. An input sampled at the reset edge is discarded, and accumulation restarts from 0 after reset is released.
- Sign extension replicates in[IN_WIDTH-1]. When OUT_WIDTH == IN_WIDTH no extension occurs.
- No latches, no asynchronous logic.
- Module must remain parameter-clean for any legal IN_WIDTH/OUT_WIDTH.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with in_valid=1, in=100 -> out=0 and out_valid=0 throughout, and for 1 cycle after release.
2. Basic accumulate (defaults): after reset, drive {clear=1,in=5}, {in=-3}, {in=7}, all valid, on consecutive edges -> out=5, 2, 9 with out_valid=1 on 3 consecutive cycles, first one 2 edges after the first input.
3. Sign extension: clear=1, in_valid=1, in=17'h10000 (-65536) -> out=32'hFFFF0000; then in=17'h1FFFF (-1) -> out=32'hFFFEFFFF.
4. Gaps and clear without valid:
   - Accumulate 10, 20 (out=30), then 4 cycles in_valid=0 -> out holds 30, out_valid=0.
   - Then clear=1, in_valid=0 -> out=0, out_valid=0.
   - Then valid in=4 -> out=4.
5. Wrap-around: instance OUT_WIDTH=18, IN_WIDTH=17; clear with in=65535, then in=65535 twice -> out=131070, then 18'h2FFFD (-65539 signed).
6. Reset mid-operation: accumulate 1,2,3 (out=6); assert reset=0 for one edge while driving in=50 valid; release and drive clear=0, in=8 valid -> out=0 after the reset edge, then out=8 (starts from 0); the 50 is never added.

Source files
------------

// File: rtl/psum_accumulator.sv
// Output accumulation stage for one systolic-array column: registers the signed
// partial sum, sign-extends it and accumulates into a wide signed register.

module psum_reg_stage #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk) begin
    if (!reset) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;
endmodule

module psum_sext_adder #(
  parameter int IN_W  = 17,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  a,
  input  logic [OUT_W-1:0] acc,
  output logic [OUT_W-1:0] a_ext,
  output logic [OUT_W-1:0] sum
);
  generate
    if (OUT_W > IN_W) begin : g_ext
      assign a_ext = {{(OUT_W-IN_W){a[IN_W-1]}}, a};
    end else begin : g_same
      assign a_ext = a;
    end
  endgenerate

  // Same-width add: carry out is dropped, giving two's-complement wrap.
  assign sum = acc + a_ext;
endmodule

module psum_acc_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] sum,
  output logic [W-1:0] q
);
  logic [W-1:0] acc_d;
  logic [W-1:0] acc_q;

  always_comb begin
    acc_d = acc_q;
    if (valid && clear) acc_d = load_val;
    else if (valid)     acc_d = sum;
    else if (clear)     acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign q = acc_q;
endmodule

// Handshake: in_valid qualifies in/clear each cycle; there is no ready, every
// cycle is accepted. out_valid is high for exactly the cycle whose out holds
// the result of a consumed valid input (2-cycle latency).
module psum_accumulator #(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid
);
  logic [IN_WIDTH+1:0]  s1_bus;
  logic                 s1_valid;
  logic                 s1_clear;
  logic [IN_WIDTH-1:0]  s1_in;
  logic [OUT_WIDTH-1:0] s1_ext;
  logic [OUT_WIDTH-1:0] acc_sum;
  logic [OUT_WIDTH-1:0] acc;

  psum_reg_stage #(.W(IN_WIDTH+2)) u_stage1 (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     ({in_valid, clear, in}),
    .q     (s1_bus)
  );

  assign s1_valid = s1_bus[IN_WIDTH+1];
  assign s1_clear = s1_bus[IN_WIDTH];
  assign s1_in    = s1_bus[IN_WIDTH-1:0];

  psum_sext_adder #(.IN_W(IN_WIDTH), .OUT_W(OUT_WIDTH)) u_adder (
    .a     (s1_in),
    .acc   (acc),
    .a_ext (s1_ext),
    .sum   (acc_sum)
  );

  psum_acc_reg #(.W(OUT_WIDTH)) u_acc (
    .clk      (clk),
    .reset    (reset),
    .valid    (s1_valid),
    .clear    (s1_clear),
    .load_val (s1_ext),
    .sum      (acc_sum),
    .q        (acc)
  );

  psum_reg_stage #(.W(1)) u_out_valid (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .d     (s1_valid),
    .q     (out_valid)
  );

  assign out = acc;
endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: default (17->32) and narrow (17->18) instances
// share stimulus; a transaction model feeds expected-result queues.

module tb_psum_accumulator;
  localparam int IW = 17;
  localparam int WW = 32;
  localparam int NW = 18;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          clr;
  logic [IW-1:0] din;
  logic [WW-1:0] out_w;
  logic          ov_w;
  logic [NW-1:0] out_n;
  logic          ov_n;

  int n_vec = 0;
  int n_bad = 0;

  logic [WW:0] exp_q[$];
  logic [NW:0] exp_n_q[$];
  logic [WW-1:0] m_acc_w;
  logic [NW-1:0] m_acc_n;

  always #5 clk = ~clk;

  psum_accumulator #(.IN_WIDTH(IW), .OUT_WIDTH(WW)) dut_w (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .clear     (clr),
    .in        (din),
    .out       (out_w),
    .out_valid (ov_w)
  );

  psum_accumulator #(.IN_WIDTH(IW), .OUT_WIDTH(NW)) dut_n (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .clear     (clr),
    .in        (din),
    .out       (out_n),
    .out_valid (ov_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, update the model, then compare the entry whose
  // result lands on this edge (the one pushed a cycle earlier).
  task automatic cycle(input logic r, input logic v, input logic c, input logic [IW-1:0] d);
    logic [WW-1:0] ext_w;
    logic [NW-1:0] ext_n;
    logic [WW:0]   e_w;
    logic [NW:0]   e_n;
    @(negedge clk);
    rst_n = r; in_valid = v; clr = c; din = d;
    ext_w = {{(WW-IW){d[IW-1]}}, d};
    ext_n = {d[IW-1], d};
    if (!r) begin
      m_acc_w = '0;
      m_acc_n = '0;
      // An input still in stage 1 at a reset edge is discarded.
      if (exp_q.size() > 0)   exp_q[exp_q.size()-1] = '0;
      if (exp_n_q.size() > 0) exp_n_q[exp_n_q.size()-1] = '0;
      exp_q.push_back('0);
      exp_n_q.push_back('0);
    end else begin
      if (v && c) begin
        m_acc_w = ext_w;
        m_acc_n = ext_n;
      end else if (v) begin
        m_acc_w = m_acc_w + ext_w;
        m_acc_n = m_acc_n + ext_n;
      end else if (c) begin
        m_acc_w = '0;
        m_acc_n = '0;
      end
      exp_q.push_back({v, m_acc_w});
      exp_n_q.push_back({v, m_acc_n});
    end
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e_w = exp_q.pop_front();
      e_n = exp_n_q.pop_front();
      check("out_w", 64'(out_w), 64'(e_w[WW-1:0]));
      check("ov_w",  64'(ov_w),  64'(e_w[WW]));
      check("out_n", 64'(out_n), 64'(e_n[NW-1:0]));
      check("ov_n",  64'(ov_n),  64'(e_n[NW]));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; din = '0;
    m_acc_w = '0; m_acc_n = '0;

    // Reset held with valid traffic, then one idle cycle after release
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 17'd100);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Basic accumulate: 5, -3, 7
    cycle(1'b1, 1'b1, 1'b1, 17'd5);
    cycle(1'b1, 1'b1, 1'b0, -17'sd3);
    cycle(1'b1, 1'b1, 1'b0, 17'd7);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Sign extension of the most negative value and -1
    cycle(1'b1, 1'b1, 1'b1, 17'h10000);
    cycle(1'b1, 1'b1, 1'b0, 17'h1FFFF);

    // Gaps, then clear without valid, then restart
    cycle(1'b1, 1'b1, 1'b1, 17'd10);
    cycle(1'b1, 1'b1, 1'b0, 17'd20);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, $urandom_range(0, 1000));
    cycle(1'b1, 1'b0, 1'b1, 17'd99);
    cycle(1'b1, 1'b1, 1'b0, 17'd4);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Wrap-around on the 18-bit instance
    cycle(1'b1, 1'b1, 1'b1, 17'd65535);
    cycle(1'b1, 1'b1, 1'b0, 17'd65535);
    cycle(1'b1, 1'b1, 1'b0, 17'd65535);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Consecutive clears
    cycle(1'b1, 1'b1, 1'b1, 17'd11);
    cycle(1'b1, 1'b1, 1'b1, 17'd22);
    cycle(1'b1, 1'b1, 1'b0, 17'd1);

    // Reset mid-stream: 50 must never be added
    cycle(1'b1, 1'b1, 1'b1, 17'd1);
    cycle(1'b1, 1'b1, 1'b0, 17'd2);
    cycle(1'b1, 1'b1, 1'b0, 17'd3);
    cycle(1'b0, 1'b1, 1'b0, 17'd50);
    cycle(1'b1, 1'b1, 1'b0, 17'd8);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Random traffic with occasional clears and resets
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), IW'($urandom_range(0, 131071)));
    end
    cycle(1'b1, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
